meta_arb: RTL

- N-way round-robin arbiter that merges metadata_t streams from several producers onto the single metadata input of the frame generator.
- Producers are per-engine match/reassembly outputs; the consumer is the Ethernet frame builder stage.
- Registered, skid-buffered output honours both out_meta_ready and the downstream out_almost_full.
- Per-port accept counters and a global stall counter support debug/stat readout.

---
 rtl/meta_arb_pkg.sv | 12 +
 rtl/meta_skid_buf.sv | 42 ++++
 rtl/meta_arb.sv | 63 ++++++
 3 files changed

// File: rtl/meta_arb_pkg.sv
// meta_arb_pkg: shared metadata beat type and round-robin helpers for the metadata arbiter.
package meta_arb_pkg;
  localparam int META_ARB_NUM_IN = 4;
  typedef struct packed {
    logic [7:0]  src_id;
    logic [15:0] flow_id;
    logic [31:0] tag;
  } metadata_t;
  function automatic logic [2:0] rr_next(input logic [2:0] g, input int n);
    return 3'((int'(g) + 1) % n);
  endfunction
endpackage

// File: rtl/meta_skid_buf.sv
// meta_skid_buf: 2-entry valid/ready register slice for metadata_t with almost_full-aware accept.
module meta_skid_buf
  import meta_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_valid,
  input  metadata_t i_data,
  output logic      o_can_accept,
  output logic      o_valid,
  output metadata_t o_data,
  input  logic      i_ready,
  input  logic      i_almost_full
);
  logic      r_main_v, r_skid_v;
  metadata_t r_main, r_skid;
  logic      w_acc, w_drain;
  assign o_can_accept = !r_skid_v && !i_almost_full;
  assign w_acc        = i_valid && o_can_accept;
  assign w_drain      = r_main_v && i_ready;
  assign o_valid      = r_main_v;
  assign o_data       = r_main;
  // A full skid implies a valid main register, so it only ever moves forward on drain.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else if (r_skid_v) begin
      if (i_ready) begin
        r_main   <= r_skid;
        r_skid_v <= 1'b0;
      end
    end else if (w_drain || !r_main_v) begin
      r_main_v <= w_acc;
      if (w_acc) r_main <= i_data;
    end else if (w_acc) begin
      r_skid_v <= 1'b1;
      r_skid   <= i_data;
    end
endmodule

// File: rtl/meta_arb.sv
// meta_arb: round-robin merge of per-engine metadata streams onto the frame builder input, with stats.
module meta_arb
  import meta_arb_pkg::*;
#(
  parameter int NUM_IN = META_ARB_NUM_IN,
  parameter int CNT_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  metadata_t [NUM_IN-1:0]         in_meta_data,
  input  logic [NUM_IN-1:0]              in_meta_valid,
  output logic [NUM_IN-1:0]              in_meta_ready,
  output metadata_t                      out_meta_data,
  output logic                           out_meta_valid,
  input  logic                           out_meta_ready,
  input  logic                           out_almost_full,
  output logic [NUM_IN-1:0][CNT_W-1:0]   stat_accept_cnt,
  output logic [CNT_W-1:0]               stat_stall_cnt
);
  localparam int PW = $clog2(NUM_IN);
  logic [PW-1:0]                 r_ptr, w_gnt, w_idx;
  logic [NUM_IN-1:0][CNT_W-1:0]  r_acc;
  logic [CNT_W-1:0]              r_stall;
  logic                          w_gnt_v, w_skid_can, w_fire;
  // Scan from the lowest priority upward so the last hit is the first valid port at or after r_ptr.
  always_comb begin
    w_gnt_v = 1'b0;
    w_gnt   = r_ptr;
    w_idx   = r_ptr;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_IN);
      if (in_meta_valid[w_idx]) begin
        w_gnt_v = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end
  assign w_fire          = rst && w_gnt_v && w_skid_can;
  assign in_meta_ready   = w_fire ? NUM_IN'(1) << w_gnt : '0;
  assign stat_accept_cnt = r_acc;
  assign stat_stall_cnt  = r_stall;
  meta_skid_buf u_skid (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (w_fire),
    .i_data        (in_meta_data[w_gnt]),
    .o_can_accept  (w_skid_can),
    .o_valid       (out_meta_valid),
    .o_data        (out_meta_data),
    .i_ready       (out_meta_ready),
    .i_almost_full (out_almost_full)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ptr   <= '0;
      r_acc   <= '0;
      r_stall <= '0;
    end else begin
      if (w_fire) r_ptr <= PW'(rr_next(3'(w_gnt), NUM_IN));
      if (|in_meta_valid && !w_fire) r_stall <= r_stall + 1'b1;
      for (int i = 0; i < NUM_IN; i++) r_acc[i] <= r_acc[i] + CNT_W'(in_meta_ready[i]);
    end
endmodule
